// File: rtl/trap_sequencer_pkg.sv
// Shared constants and types for the machine-mode trap sequencer:
// CSR addresses, mstatus bit positions, cause codes and FSM encodings.
package trap_sequencer_pkg;

    localparam int unsigned XLEN_32b = 1;
    localparam int unsigned XLEN_64b = 2;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam int unsigned CAUSE_ECALL_M  = 11;
    localparam int unsigned CAUSE_MEXT_IRQ = 11;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DRAIN       = 3'd1,
        ST_SAVE_EPC    = 3'd2,
        ST_SAVE_CAUSE  = 3'd3,
        ST_SAVE_STATUS = 3'd4,
        ST_MRET_STATUS = 3'd5,
        ST_REDIRECT    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_ECALL = 2'd1,
        KIND_MRET  = 2'd2,
        KIND_IRQ   = 2'd3
    } kind_e;

endpackage

// File: rtl/trap_sequencer_csr_port_arbiter.sv
// Owner mux for the single CSR write port; records a sticky conflict when the
// pipeline tries to write while the sequencer holds the port.
module trap_sequencer_csr_port_arbiter #(
    parameter int unsigned DW = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_seq_own,
    input  logic [11:0]   i_seq_addr,
    input  logic [DW-1:0] i_seq_data,
    input  logic          i_pipe_we,
    input  logic [11:0]   i_pipe_addr,
    input  logic [DW-1:0] i_pipe_data,
    output logic          o_we,
    output logic [11:0]   o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_conflict
);

    logic conflict_d;
    logic conflict_q;

    always_comb begin
        o_we   = i_pipe_we;
        o_addr = i_pipe_addr;
        o_data = i_pipe_data;
        if (i_seq_own) begin
            o_we   = 1'b1;
            o_addr = i_seq_addr;
            o_data = i_seq_data;
        end
    end

    // A pipeline request while the sequencer owns the port is lost; remember it.
    always_comb begin
        conflict_d = conflict_q | (i_seq_own & i_pipe_we);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign o_conflict = conflict_q;

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: drains pending CSR writes, saves
// mepc/mcause/mstatus one write per cycle, then redirects the PC.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_64b,
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    localparam int unsigned DW          = 1 << (XLEN + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ecall_e,
    input  logic          i_mret_e,
    input  logic          i_valid_e,
    input  logic [DW-1:0] i_pc_e,
    input  logic          i_irq,
    input  logic          i_csr_pending,
    input  logic          i_csr_reg_write_w,
    input  logic [11:0]   i_csr_rd_w,
    input  logic [DW-1:0] i_new_csr_w,
    input  logic [DW-1:0] i_mstatus,
    input  logic [DW-1:0] i_mtvec,
    input  logic [DW-1:0] i_mepc,
    output logic          o_csr_we,
    output logic [11:0]   o_csr_waddr,
    output logic [DW-1:0] o_csr_wdata,
    output logic          o_flush_fde,
    output logic          o_stall_fd,
    output logic          o_redirect_valid,
    output logic [DW-1:0] o_redirect_pc,
    output logic          o_busy,
    output logic          o_conflict
);

    localparam logic [DW-1:0] CAUSE_IRQ_VAL = {1'b1, {(DW-1){1'b0}}} | DW'(CAUSE_MEXT_IRQ);

    // The sequence never uses the reset vector, but the CSR file derives the
    // mtvec default from it and mtvec requires 4-byte alignment.
    if (RESET_VECTOR[1:0] != 2'b00) begin : g_reset_vector_check
        $error("RESET_VECTOR must be 4-byte aligned");
    end

    function automatic logic [DW-1:0] trap_entry_mstatus(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [DW-1:0] mret_mstatus(input logic [DW-1:0] s);
        logic [DW-1:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    state_e        state_d, state_q;
    kind_e         kind_d, kind_q;
    logic [DW-1:0] epc_d, epc_q;
    logic [DW-1:0] cause_d, cause_q;

    logic          irq_take;
    logic          seq_own;
    logic [11:0]   seq_addr;
    logic [DW-1:0] seq_data;
    logic [DW-1:0] mtvec_base;

    assign irq_take   = i_irq & i_mstatus[MSTATUS_MIE] & i_valid_e;
    assign mtvec_base = i_mtvec & ~DW'(3);

    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        epc_d            = epc_q;
        cause_d          = cause_q;
        seq_own          = 1'b0;
        seq_addr         = '0;
        seq_data         = '0;
        o_flush_fde      = 1'b0;
        o_stall_fd       = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_ecall_e || i_mret_e || irq_take) begin
                    o_flush_fde = 1'b1;
                    epc_d       = i_pc_e;
                    state_d     = ST_DRAIN;
                    if (i_ecall_e) begin
                        kind_d  = KIND_ECALL;
                        cause_d = DW'(CAUSE_ECALL_M);
                    end else if (i_mret_e) begin
                        kind_d  = KIND_MRET;
                        cause_d = '0;
                    end else begin
                        kind_d  = KIND_IRQ;
                        cause_d = CAUSE_IRQ_VAL;
                    end
                end
            end
            ST_DRAIN: begin
                o_stall_fd = 1'b1;
                if (!i_csr_pending) begin
                    state_d = (kind_q == KIND_MRET) ? ST_MRET_STATUS : ST_SAVE_EPC;
                end
            end
            ST_SAVE_EPC: begin
                o_stall_fd = 1'b1;
                seq_own    = 1'b1;
                seq_addr   = CSR_MEPC;
                seq_data   = epc_q & ~DW'(1);
                state_d    = ST_SAVE_CAUSE;
            end
            ST_SAVE_CAUSE: begin
                o_stall_fd = 1'b1;
                seq_own    = 1'b1;
                seq_addr   = CSR_MCAUSE;
                seq_data   = cause_q;
                state_d    = ST_SAVE_STATUS;
            end
            ST_SAVE_STATUS: begin
                o_stall_fd = 1'b1;
                seq_own    = 1'b1;
                seq_addr   = CSR_MSTATUS;
                seq_data   = trap_entry_mstatus(i_mstatus);
                state_d    = ST_REDIRECT;
            end
            ST_MRET_STATUS: begin
                o_stall_fd = 1'b1;
                seq_own    = 1'b1;
                seq_addr   = CSR_MSTATUS;
                seq_data   = mret_mstatus(i_mstatus);
                state_d    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                o_stall_fd       = 1'b1;
                o_flush_fde      = 1'b1;
                o_redirect_valid = 1'b1;
                // Vectored mode offsets only interrupts; exceptions use the base.
                if (kind_q == KIND_MRET) begin
                    o_redirect_pc = i_mepc;
                end else if (i_mtvec[1:0] == 2'b01 && kind_q == KIND_IRQ) begin
                    o_redirect_pc = mtvec_base + DW'(4 * CAUSE_MEXT_IRQ);
                end else begin
                    o_redirect_pc = mtvec_base;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_NONE;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);

    trap_sequencer_csr_port_arbiter #(
        .DW (DW)
    ) u_csr_port_arbiter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_seq_own   (seq_own),
        .i_seq_addr  (seq_addr),
        .i_seq_data  (seq_data),
        .i_pipe_we   (i_csr_reg_write_w),
        .i_pipe_addr (i_csr_rd_w),
        .i_pipe_data (i_new_csr_w),
        .o_we        (o_csr_we),
        .o_addr      (o_csr_waddr),
        .o_data      (o_csr_wdata),
        .o_conflict  (o_conflict)
    );

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected CSR writes and redirects are
// queued when stimulus is driven and checked as the DUT emits them.
module tb_trap_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ecall_e, i_mret_e, i_valid_e, i_irq, i_csr_pending;
    logic [63:0] i_pc_e;
    logic        i_csr_reg_write_w;
    logic [11:0] i_csr_rd_w;
    logic [63:0] i_new_csr_w, i_mstatus, i_mtvec, i_mepc;
    logic        o_csr_we, o_flush_fde, o_stall_fd, o_redirect_valid, o_busy, o_conflict;
    logic [11:0] o_csr_waddr;
    logic [63:0] o_csr_wdata, o_redirect_pc;

    trap_sequencer dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_ecall_e         (i_ecall_e),
        .i_mret_e          (i_mret_e),
        .i_valid_e         (i_valid_e),
        .i_pc_e            (i_pc_e),
        .i_irq             (i_irq),
        .i_csr_pending     (i_csr_pending),
        .i_csr_reg_write_w (i_csr_reg_write_w),
        .i_csr_rd_w        (i_csr_rd_w),
        .i_new_csr_w       (i_new_csr_w),
        .i_mstatus         (i_mstatus),
        .i_mtvec           (i_mtvec),
        .i_mepc            (i_mepc),
        .o_csr_we          (o_csr_we),
        .o_csr_waddr       (o_csr_waddr),
        .o_csr_wdata       (o_csr_wdata),
        .o_flush_fde       (o_flush_fde),
        .o_stall_fd        (o_stall_fd),
        .o_redirect_valid  (o_redirect_valid),
        .o_redirect_pc     (o_redirect_pc),
        .o_busy            (o_busy),
        .o_conflict        (o_conflict)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [11:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t         exp_w[$];
    logic [63:0] exp_r[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every emitted write/redirect must match the head of its queue.
    always @(negedge i_clk) begin
        wr_t w;
        if (o_csr_we === 1'b1) begin
            if (exp_w.size() == 0) begin
                chk("unexpected_write", o_csr_we, 64'd0);
            end else begin
                w = exp_w.pop_front();
                chk("wr_addr", {52'd0, o_csr_waddr}, {52'd0, w.a});
                chk("wr_data", o_csr_wdata, w.d);
            end
        end
        if (o_redirect_valid === 1'b1) begin
            if (exp_r.size() == 0) begin
                chk("unexpected_redirect", o_redirect_valid, 64'd0);
            end else begin
                chk("redirect_pc", o_redirect_pc, exp_r.pop_front());
            end
        end
    end

    task automatic to_next();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_in();
        i_ecall_e = 0; i_mret_e = 0; i_valid_e = 0; i_irq = 0; i_csr_pending = 0;
        i_pc_e = '0; i_csr_reg_write_w = 0; i_csr_rd_w = '0; i_new_csr_w = '0;
        i_mstatus = '0; i_mtvec = '0; i_mepc = '0;
    endtask

    task automatic push_trap(input logic [63:0] pc, input logic [63:0] cause,
                             input logic [63:0] status, input logic [63:0] target);
        exp_w.push_back({12'h341, pc & ~64'h1});
        exp_w.push_back({12'h342, cause});
        exp_w.push_back({12'h300, status});
        exp_r.push_back(target);
    endtask

    task automatic check_queues_empty(input string tag);
        chk({tag, "_writes_left"}, 64'(exp_w.size()), 64'd0);
        chk({tag, "_redirects_left"}, 64'(exp_r.size()), 64'd0);
    endtask

    // Starts just after the trigger cycle was sampled; ends at a drive point.
    task automatic run_to_idle(input string tag, input int redir_at);
        for (int c = 1; c <= redir_at + 1; c++) begin
            to_next();
            i_ecall_e = 0; i_mret_e = 0; i_irq = 0;
            @(negedge i_clk);
            chk({tag, "_redirect_valid"}, {63'd0, o_redirect_valid}, 64'(c == redir_at));
            chk({tag, "_busy"}, {63'd0, o_busy}, 64'(c <= redir_at));
            chk({tag, "_stall"}, {63'd0, o_stall_fd}, 64'(c <= redir_at));
            if (c == redir_at) chk({tag, "_flush_redirect"}, {63'd0, o_flush_fde}, 64'd1);
        end
        to_next();
        check_queues_empty(tag);
    endtask

    initial begin
        clear_in();
        i_rst_n = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            chk("rst_we", {63'd0, o_csr_we}, 64'd0);
            chk("rst_flush", {63'd0, o_flush_fde}, 64'd0);
            chk("rst_stall", {63'd0, o_stall_fd}, 64'd0);
            chk("rst_redirect", {63'd0, o_redirect_valid}, 64'd0);
            chk("rst_busy", {63'd0, o_busy}, 64'd0);
            chk("rst_conflict", {63'd0, o_conflict}, 64'd0);
        end
        to_next();
        i_rst_n = 1'b1;

        // Pipeline csrrw in IDLE passes straight through.
        i_csr_reg_write_w = 1; i_csr_rd_w = 12'h340; i_new_csr_w = 64'hAA;
        exp_w.push_back({12'h340, 64'hAA});
        @(negedge i_clk);
        chk("pipe_busy", {63'd0, o_busy}, 64'd0);
        chk("pipe_flush", {63'd0, o_flush_fde}, 64'd0);
        to_next();
        clear_in();
        check_queues_empty("pipe");

        // ecall with no drain wait.
        i_pc_e = 64'h1000; i_mstatus = 64'h8; i_mtvec = 64'h2000; i_valid_e = 1; i_ecall_e = 1;
        push_trap(64'h1000, 64'd11, 64'h1880, 64'h2000);
        @(negedge i_clk);
        chk("ecall_flush_c0", {63'd0, o_flush_fde}, 64'd1);
        chk("ecall_busy_c0", {63'd0, o_busy}, 64'd0);
        run_to_idle("ecall", 5);

        // ecall with pending CSR writes: DRAIN holds 3 cycles, pipeline writes pass.
        i_pc_e = 64'h1100; i_ecall_e = 1; i_csr_pending = 1;
        @(negedge i_clk);
        chk("drain_flush_c0", {63'd0, o_flush_fde}, 64'd1);
        for (int c = 1; c <= 8; c++) begin
            to_next();
            i_ecall_e = 0;
            i_csr_pending = (c < 3);
            if (c <= 3) begin
                i_csr_reg_write_w = 1; i_csr_rd_w = 12'h340; i_new_csr_w = 64'h10 + 64'(c);
                exp_w.push_back({12'h340, 64'h10 + 64'(c)});
            end else begin
                i_csr_reg_write_w = 0;
            end
            if (c == 3) push_trap(64'h1100, 64'd11, 64'h1880, 64'h2000);
            @(negedge i_clk);
            chk("drain_redirect_valid", {63'd0, o_redirect_valid}, 64'(c == 7));
            chk("drain_busy", {63'd0, o_busy}, 64'(c <= 7));
        end
        to_next();
        check_queues_empty("drain");
        chk("drain_no_conflict", {63'd0, o_conflict}, 64'd0);

        // Interrupt, vectored mtvec; irq drops after the trigger cycle.
        i_pc_e = 64'h400; i_mstatus = 64'h8; i_mtvec = 64'h2001; i_irq = 1; i_valid_e = 1;
        push_trap(64'h400, 64'h8000_0000_0000_000B, 64'h1880, 64'h202C);
        @(negedge i_clk);
        chk("irq_flush_c0", {63'd0, o_flush_fde}, 64'd1);
        run_to_idle("irq", 5);

        // Interrupt masked by MIE, then blocked by a bubble in EX.
        i_mstatus = 64'h0; i_irq = 1;
        @(negedge i_clk);
        chk("irq_masked_flush", {63'd0, o_flush_fde}, 64'd0);
        to_next();
        i_mstatus = 64'h8; i_valid_e = 0;
        @(negedge i_clk);
        chk("irq_masked_busy", {63'd0, o_busy}, 64'd0);
        chk("irq_bubble_flush", {63'd0, o_flush_fde}, 64'd0);
        to_next();
        i_irq = 0; i_valid_e = 1;
        @(negedge i_clk);
        chk("irq_bubble_busy", {63'd0, o_busy}, 64'd0);
        to_next();

        // mret.
        i_mstatus = 64'h1880; i_mepc = 64'h1004; i_mret_e = 1;
        exp_w.push_back({12'h300, 64'h1888});
        exp_r.push_back(64'h1004);
        @(negedge i_clk);
        chk("mret_flush_c0", {63'd0, o_flush_fde}, 64'd1);
        run_to_idle("mret", 3);

        // ecall and mret together: ecall wins.
        i_pc_e = 64'h1000; i_mstatus = 64'h8; i_mtvec = 64'h2000; i_mepc = 64'h1004;
        i_ecall_e = 1; i_mret_e = 1;
        push_trap(64'h1000, 64'd11, 64'h1880, 64'h2000);
        @(negedge i_clk);
        run_to_idle("ecall_mret", 5);

        // Pipeline write during SAVE_EPC is dropped and flagged.
        i_pc_e = 64'h500; i_ecall_e = 1;
        push_trap(64'h500, 64'd11, 64'h1880, 64'h2000);
        @(negedge i_clk);
        for (int c = 1; c <= 6; c++) begin
            to_next();
            i_ecall_e = 0;
            i_csr_reg_write_w = (c == 2);
            i_csr_rd_w = 12'h340; i_new_csr_w = 64'hDEAD;
            @(negedge i_clk);
            if (c == 2) chk("conflict_before", {63'd0, o_conflict}, 64'd0);
            if (c == 3) chk("conflict_set", {63'd0, o_conflict}, 64'd1);
        end
        to_next();
        check_queues_empty("conflict");
        chk("conflict_sticky", {63'd0, o_conflict}, 64'd1);

        // Reset during SAVE_CAUSE: only the mepc write happens, no redirect.
        i_pc_e = 64'h3000; i_ecall_e = 1;
        exp_w.push_back({12'h341, 64'h3000});
        @(negedge i_clk);
        for (int c = 1; c <= 2; c++) begin
            to_next();
            i_ecall_e = 0;
            @(negedge i_clk);
        end
        to_next();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("midrst_we", {63'd0, o_csr_we}, 64'd0);
        chk("midrst_busy", {63'd0, o_busy}, 64'd0);
        chk("midrst_stall", {63'd0, o_stall_fd}, 64'd0);
        chk("midrst_flush", {63'd0, o_flush_fde}, 64'd0);
        chk("midrst_conflict", {63'd0, o_conflict}, 64'd0);
        to_next();
        i_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            chk("postrst_busy", {63'd0, o_busy}, 64'd0);
            chk("postrst_redirect", {63'd0, o_redirect_valid}, 64'd0);
            to_next();
        end
        check_queues_empty("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap controller in the execute/writeback boundary; owns the single CSR register-file write port.
- Arbitrates that port between the pipeline CSR write (csrrw/csrrs/csrrc retiring in WB) and its own multi-cycle trap and mret sequences.
- On ecall_e, mret_e or a qualified external interrupt: flushes younger stages, stalls fetch/decode, drains in-flight CSR writes, updates mepc/mcause/mstatus one write per cycle, then redirects the PC.

Parameters:
- XLEN, `XLEN_64b, width code; data width DW = 1<<(XLEN+4).
- RESET_VECTOR, 0, unused by the sequence; reserved for the mtvec default in the CSR file.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ecall_e  in  1  ecall in EX
- i_mret_e  in  1  mret in EX
- i_valid_e  in  1  EX holds a real instruction, not a bubble
- i_pc_e  in  DW  PC of the EX instruction
- i_irq  in  1  level machine external interrupt
- i_csr_pending  in  1  CSR write in MEM or WB not yet retired
- i_csr_reg_write_w  in  1  pipeline CSR write request
- i_csr_rd_w  in  12  pipeline CSR address
- i_new_csr_w  in  DW  pipeline CSR data
- i_mstatus, i_mtvec, i_mepc  in  DW each  current CSR values, combinational read
- o_csr_we  out  1  CSR port write enable
- o_csr_waddr  out  12  CSR port address
- o_csr_wdata  out  DW  CSR port data
- o_flush_fde  out  1  flush IF/ID/EX
- o_stall_fd  out  1  stall PC and IF/ID
- o_redirect_valid  out  1  load o_redirect_pc into the PC
- o_redirect_pc  out  DW  next PC
- o_busy  out  1  state != IDLE
- o_conflict  out  1  sticky; pipeline write arrived during a sequence write state

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; latched epc, cause and kind 0; o_conflict cleared. Reset mid-sequence abandons the sequence with no partial write and no redirect.
- CSR port mux:
  - IDLE/DRAIN: port = pipeline inputs, passed through combinationally.
  - SAVE_*/MRET_STATUS: port = sequencer; the pipeline request is dropped and o_conflict is set.
- Trigger, IDLE only, priority ecall > mret > irq:
  - irq qualifies only when i_irq & i_mstatus[3] (MIE) & i_valid_e.
  - Trigger cycle: o_flush_fde=1 (combinational); latch epc=i_pc_e and kind; cause = 11 for ecall, or (1<<(DW-1))|11 for irq; next state DRAIN.
- FSM:
  - DRAIN: stall; stay while i_csr_pending=1; exit to SAVE_EPC on trap, MRET_STATUS on mret. Minimum 1 cycle.
  - SAVE_EPC: write 0x341 = epc & ~1.
  - SAVE_CAUSE: write 0x342 = cause.
  - SAVE_STATUS: write 0x300 = i_mstatus with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - MRET_STATUS: write 0x300 = i_mstatus with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
  - REDIRECT: o_redirect_valid=1 for exactly 1 cycle.
    - Trap target: base = i_mtvec & ~3. If i_mtvec[1:0]==01 and the trap is an interrupt, target = base + 4*11; otherwise target = base.
    - mret target: i_mepc.
    - Next state IDLE.
- o_stall_fd=1 in every non-IDLE state. o_flush_fde is also 1 in REDIRECT.
- Latency with no drain wait: ecall at cycle 0 -> 4 write cycles (DRAIN, 3 SAVE) -> redirect at cycle 5. mret: redirect at cycle 3.
- Triggers arriving while busy are ignored; the flushed pipeline cannot present them.
- irq deasserting after the trigger cycle does not cancel the trap.
- Writes are DW-wide. Bits outside those listed are preserved from i_mstatus.

Decomposition:
- riscv_defines.vh gains:
  - CSR addresses: CSR_MSTATUS 0x300, CSR_MTVEC 0x305, CSR_MEPC 0x341, CSR_MCAUSE 0x342
  - mstatus bit indices: MIE 3, MPIE 7, MPP 12:11
  - cause code CAUSE_ECALL_M 11, CAUSE_MEXT_IRQ 11
  - state encodings
- One sub-module, csr_port_arbiter: the combinational mux plus conflict flag. FSM, latches and redirect logic stay in the top.

Test Plan:
- Pipeline csrrw in IDLE: i_csr_reg_write_w=1, addr 0x340, data 0xAA -> same cycle o_csr_we=1, waddr 0x340, wdata 0xAA; o_busy=0.
- ecall, pc_e=0x1000, mstatus=0x8, mtvec=0x2000, pending=0 -> flush at cycle 0; then writes mepc=0x1000, mcause=11, mstatus=0x1880; redirect 0x2000 at cycle 5.
- ecall with i_csr_pending held 3 cycles -> DRAIN lasts 3 cycles, pipeline WB writes pass through meanwhile; mepc write follows on the next cycle.
- irq=1, mstatus=0x8, mtvec=0x2001, pc_e=0x400 -> mcause=0x8000_0000_0000_000B, mepc=0x400, redirect 0x202C. Same stimulus with mstatus=0 -> no trigger.
- mret, mstatus=0x1880, mepc=0x1004 -> mstatus write 0x1888; redirect 0x1004 at cycle 3. ecall and mret in the same cycle -> ecall path taken.
- i_rst_n low during SAVE_CAUSE -> outputs 0 immediately, no further writes, no redirect. Pipeline write during SAVE_EPC -> dropped, o_conflict=1 until reset.
